alu_cmd_driver: RTL
===================

Name: alu_cmd_driver

Overview:
- Initiator-side sequencer for the registered ALU datapath.
- Accepts operation commands from a host over a valid/ready interface and drives operands, select and enable into the ALU.
- Waits the ALU's registered latency, captures result and flags, and returns one response per command over a valid/ready interface with backpressure.
- Pre-screens divide-by-zero so the ALU is never issued an invalid division.

Parameters:
- WIDTH, 4, operand width; ALU result width is 2*WIDTH.
- LATENCY, 1, clock cycles from the ALU sampling enable=1 to its result being valid (minimum 1).
- COUNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- arst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  driver can accept a command
- cmd_a  input  WIDTH  operand a
- cmd_b  input  WIDTH  operand b
- cmd_op  input  3  ALU select code (000 add … 111 div)
- alu_a  output  WIDTH  operand a to ALU, registered
- alu_b  output  WIDTH  operand b to ALU, registered
- alu_select  output  3  select to ALU, registered
- alu_enable  output  1  enable to ALU, registered
- alu_out  input  2*WIDTH  ALU result
- alu_carry  input  1  ALU carry out
- alu_greater, alu_equal, alu_less  input  1 each  ALU compare flags
- rsp_valid  output  1  response valid
- rsp_ready  input  1  host accepts response
- rsp_data  output  2*WIDTH  captured result
- rsp_carry  output  1  captured carry (add only; 0 otherwise)
- rsp_flags  output  3  {greater, equal, less} captured with result
- rsp_err  output  1  1 = divide by zero, command not issued
- op_count  output  COUNT_W  count of completed response handshakes

Behaviour:
- Reset (arst=1 at a clk edge):
  - state returns to IDLE.
  - All outputs are 0 except cmd_ready, which is 1 in the first cycle after reset.
  - op_count is 0.
  - An in-flight command is aborted and produces no response.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1; alu_enable=0.
  - On cmd_valid&cmd_ready, latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_select.
  - If cmd_op==3'b111 and cmd_b==0: go to RESP with rsp_err=1, rsp_data=0, rsp_carry=0, rsp_flags=0. The ALU is never enabled.
  - Otherwise go to ISSUE.
- ISSUE: alu_enable=1 for this cycle; operands held. If LATENCY==1 go to CAPTURE, else go to WAIT.
- WAIT:
  - alu_enable stays 1 and operands stay held, so the ALU does not clear its output.
  - A down-counter loaded with LATENCY-1 decrements each cycle; at 0, go to CAPTURE.
- CAPTURE:
  - alu_enable=0; operands still held.
  - At the clock edge ending this cycle, register:
    - rsp_data=alu_out
    - rsp_carry=alu_carry if alu_select==000, else 0
    - rsp_flags={alu_greater, alu_equal, alu_less}
    - rsp_err=0
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_* stable until handshake; cmd_ready=0.
  - On rsp_valid&rsp_ready: op_count+=1 (wraps modulo 2^COUNT_W), then go to IDLE with rsp_valid=0.
- Timing (LATENCY=1), with the command handshake at cycle 0:
  - alu_enable high in cycle 1.
  - Capture in cycle 2.
  - rsp_valid first high in cycle 3.
  - General case: rsp_valid rises LATENCY+2 cycles after the handshake; divide-by-zero responses rise 1 cycle after.
- Throughput: one command per LATENCY+3 cycles at best. No overlap; cmd_ready is 0 from the handshake until the response handshake completes.
- cmd_* are ignored outside IDLE.
- alu_a/alu_b/alu_select retain their last values after the response.
- rsp_data is passed through from the ALU unchanged:
  - zero-extended for 4-bit results;
  - equality op (101) yields 0 or 1.

Test Plan:
- WIDTH=4, LATENCY=1, add a=9 b=8, rsp_ready=1: alu_enable high only in cycle 1; rsp_valid in cycle 3 with rsp_data=8'h01, rsp_carry=1, rsp_flags=3'b100, rsp_err=0; op_count=1.
- mul a=15 b=15: rsp_data=8'hE1, rsp_carry=0, rsp_flags=3'b010. Then sub a=3 b=3 -> rsp_data=0, flags=3'b010.
- div a=7 b=0: alu_enable never asserts; rsp_valid 1 cycle after handshake with rsp_err=1, rsp_data=0. Follow with div a=7 b=2 -> rsp_data=3, rsp_err=0.
- Backpressure: after add a=1 b=2, hold rsp_ready=0 for 5 cycles. Then:
  - rsp_valid stays 1 with rsp_data=3 stable;
  - cmd_ready stays 0 and a pending cmd_valid is not accepted;
  - op_count is unchanged until the rsp_ready handshake.
- Reset mid-op with LATENCY=3: assert arst during WAIT. Next cycle: alu_enable=0, rsp_valid=0, cmd_ready=1, op_count=0; no response is ever produced for the aborted command.
- COUNT_W=2: complete 4 add commands back-to-back with rsp_ready=1. op_count sequence 1,2,3,0.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: host cmd (valid/ready) -> registered ALU issue, waits LATENCY, captures result/flags, returns rsp (valid/ready), screens div-by-zero, counts completed responses
module alu_cmd_driver #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [2:0]         cmd_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_select,
  output logic               alu_enable,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_carry,
  input  logic               alu_greater,
  input  logic               alu_equal,
  input  logic               alu_less,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_carry,
  output logic [2:0]         rsp_flags,
  output logic               rsp_err,
  output logic [COUNT_W-1:0] op_count
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_ready  <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      alu_enable <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          alu_a      <= cmd_a;
          alu_b      <= cmd_b;
          alu_select <= cmd_op;
          cmd_ready  <= 1'b0;
          if (cmd_op == 3'b111 && cmd_b == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_flags <= '0;
            state_q   <= RESP;
          end else begin
            alu_enable <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q      <= CW'(LATENCY - 1);
          alu_enable <= LATENCY > 1;
          state_q    <= LATENCY == 1 ? CAPTURE : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            alu_enable <= 1'b0;
            state_q    <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_data  <= alu_out;
          rsp_carry <= alu_select == 3'b000 && alu_carry;
          rsp_flags <= {alu_greater, alu_equal, alu_less};
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 1'b1;
          cmd_ready <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
